// File: rtl/zbuf_readback.sv
// zbuf_readback: raster-order Z-buffer region readback onto a valid/ready pixel stream
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   start, x_max, y_max        frame request; inclusive bounds latched on an accepted start
//   busy, done                 frame in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr        registered read strobe and {y,x} address
//   mem_rd_data                read data, RD_LATENCY cycles after mem_rd_en
//   pix_valid, pix_ready       output stream handshake
//   pix_data, pix_x, pix_y     depth sample and its coordinates
//   pix_last                   sample is (x_max, y_max)
module zbuf_readback #(
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 8,
    parameter int DEPTH_BITS = 16,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [X_BITS-1:0]        x_max,
    input  logic [Y_BITS-1:0]        y_max,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [X_BITS+Y_BITS-1:0] mem_addr,
    input  logic [DEPTH_BITS-1:0]    mem_rd_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [DEPTH_BITS-1:0]    pix_data,
    output logic [X_BITS-1:0]        pix_x,
    output logic [Y_BITS-1:0]        pix_y,
    output logic                     pix_last
);
    localparam int AW = X_BITS + Y_BITS;
    localparam int TW = AW + 2;
    localparam int EW = DEPTH_BITS + AW + 1;
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] P_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0] FD = (CW + 1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    state_t state_q, state_d;
    logic [X_BITS-1:0] x_q, x_d, xm_q, xm_d, cx, cxm;
    logic [Y_BITS-1:0] y_q, y_d, ym_q, ym_d, cy, cym;
    logic rd_en_q, rd_en_d, rd_last_q, rd_last_d, done_q, done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [TW-1:0] trk_q [RD_LATENCY];
    logic [TW-1:0] trk_d [RD_LATENCY];
    logic [EW-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d, out_q, out_d;
    logic [CW:0] out_nx;
    logic go, issue, is_last, push, pop;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign done      = done_q;
    // tracker tag layout: {valid, last, y, x}
    assign push      = trk_q[RD_LATENCY-1][TW-1];
    assign pix_valid = cnt_q != '0;
    assign pop       = pix_valid && pix_ready;
    assign {pix_last, pix_y, pix_x, pix_data} = pix_valid ? fifo_q[rd_q] : '0;
    always_comb begin
        go = state_q == IDLE && start && !done_q;
        // out_q counts reads from earlier cycles not yet popped; a new read is
        // granted only if the FIFO is guaranteed a free slot when its data lands
        out_nx = {1'b0, out_q} + (CW + 1)'(rd_en_q) - (CW + 1)'(pop);
        issue = go || (state_q == READ && out_nx < FD);
        cx = go ? '0 : x_q;
        cy = go ? '0 : y_q;
        cxm = go ? x_max : xm_q;
        cym = go ? y_max : ym_q;
        is_last = cx == cxm && cy == cym;
        rd_en_d = issue;
        rd_last_d = issue && is_last;
        addr_d = issue ? {cy, cx} : addr_q;
        x_d = issue ? (cx == cxm ? '0 : cx + 1'b1) : x_q;
        y_d = issue ? (cx == cxm ? cy + 1'b1 : cy) : y_q;
        xm_d = cxm;
        ym_d = cym;
        out_d = out_nx[CW-1:0];
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        wr_d = push ? (wr_q == P_LAST ? '0 : wr_q + 1'b1) : wr_q;
        rd_d = pop ? (rd_q == P_LAST ? '0 : rd_q + 1'b1) : rd_q;
        done_d = pop && pix_last;
        trk_d[0] = {rd_en_q, rd_last_q, addr_q};
        for (int i = 1; i < RD_LATENCY; i++) trk_d[i] = trk_q[i-1];
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = go ? (is_last ? DRAIN : READ) : IDLE;
            READ:    state_d = issue && is_last ? DRAIN : READ;
            DRAIN:   state_d = pop && pix_last ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_comb busy = state_q != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            xm_q      <= '0;
            ym_q      <= '0;
            rd_en_q   <= 1'b0;
            rd_last_q <= 1'b0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            for (int i = 0; i < RD_LATENCY; i++) trk_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            xm_q      <= xm_d;
            ym_q      <= ym_d;
            rd_en_q   <= rd_en_d;
            rd_last_q <= rd_last_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            trk_q     <= trk_d;
        end
    end
    // storage needs no reset: entries are only visible while counted in cnt_q
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= {trk_q[RD_LATENCY-1][AW:0], mem_rd_data};
    end
endmodule

// File: tb/tb_zbuf_readback.sv
// tb_zbuf_readback: randomized frame readback against a raster-order scoreboard
module tb_zbuf_readback;
    localparam int L  = 2;
    localparam int FD = 4;
    logic clk = 0, reset = 1, start = 0, pix_ready = 1;
    logic [7:0] x_max = 0, y_max = 0;
    logic [15:0] mem_rd_data = 0;
    logic busy, done, mem_rd_en, pix_valid, pix_last;
    logic [15:0] mem_addr, pix_data;
    logic [7:0] pix_x, pix_y;
    int total = 0, bad = 0, cyc = 0;
    bit mon_en = 0, exp_done = 0, prev_stall = 0;
    int outst = 0, first_valid = -1;
    logic [15:0] rd_exp [$];
    logic [32:0] pix_exp [$];
    logic [32:0] exp_e;
    logic [33:0] prev_vec;
    logic hv [L];
    logic [15:0] ha [L];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zbuf_readback dut (
        .clk(clk), .reset(reset), .start(start), .x_max(x_max), .y_max(y_max),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // memory: a read seen in cycle c returns {y,x} as data during cycle c+L
    always @(negedge clk) begin
        for (int i = L - 1; i > 0; i--) begin
            hv[i] = hv[i-1];
            ha[i] = ha[i-1];
        end
        hv[0] = mem_rd_en;
        ha[0] = mem_addr;
    end
    always @(posedge clk) begin
        #1;
        mem_rd_data = hv[L-1] === 1'b1 ? ha[L-1] : 16'($urandom);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("done", done, exp_done);
            if (done) check("busy_at_done", busy, 0);
            exp_done = 0;
            if (prev_stall) check("hold", {pix_valid, pix_last, pix_y, pix_x, pix_data}, prev_vec);
            if (mem_rd_en) begin
                outst++;
                if (rd_exp.size() == 0) check("extra_rd", rd_exp.size(), 1);
                else check("rd_addr", mem_addr, rd_exp.pop_front());
                check("credit", outst > FD, 0);
            end
            if (pix_valid && first_valid < 0) first_valid = cyc;
            if (pix_valid && pix_ready) begin
                outst--;
                if (pix_exp.size() == 0) check("extra_pix", pix_exp.size(), 1);
                else begin
                    exp_e = pix_exp.pop_front();
                    check("pix", {pix_last, pix_y, pix_x, pix_data}, exp_e);
                    exp_done = exp_e[32];
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_vec = {pix_valid, pix_last, pix_y, pix_x, pix_data};
        end
    end

    // mode 0: always ready, 1: stall cycles 3..12, 2: random ready
    task automatic run_frame(input int xm, input int ym, input int mode, input bit pulse, input int abort);
        int s0;
        bit seen;
        logic [15:0] a;
        rd_exp.delete();
        pix_exp.delete();
        for (int yy = 0; yy <= ym; yy++)
            for (int xx = 0; xx <= xm; xx++) begin
                a = {8'(yy), 8'(xx)};
                rd_exp.push_back(a);
                pix_exp.push_back({xx == xm && yy == ym, a, a});
            end
        first_valid = -1;
        @(posedge clk);
        #1;
        start = 1;
        x_max = 8'(xm);
        y_max = 8'(ym);
        pix_ready = 1;
        s0 = cyc;
        @(negedge clk);
        check("busy_c0", busy, 0);
        check("rd_c0", mem_rd_en, 0);
        seen = 0;
        for (int k = 1; k < 600 && !seen; k++) begin
            @(posedge clk);
            #1;
            start = pulse && k == 2;
            x_max = 8'($urandom);
            y_max = 8'($urandom);
            pix_ready = mode == 1 ? !(k >= 3 && k <= 12) : mode == 2 ? $urandom_range(0, 2) != 0 : 1'b1;
            if (k == abort) begin
                reset = 1;
                mon_en = 0;
                #1;
                check("rst_out", {busy, done, mem_rd_en, mem_addr, pix_valid, pix_last, pix_x, pix_y, pix_data}, 0);
                rd_exp.delete();
                pix_exp.delete();
                outst = 0;
                exp_done = 0;
                prev_stall = 0;
                repeat (2) @(posedge clk);
                #1;
                reset = 0;
                pix_ready = 1;
                repeat (6) begin
                    @(negedge clk);
                    check("stale", {pix_valid, mem_rd_en, busy}, 0);
                end
                mon_en = 1;
                return;
            end
            @(negedge clk);
            if (k == 1) begin
                check("busy_c1", busy, 1);
                check("rd_c1", mem_rd_en, 1);
            end
            if (done) begin
                seen = 1;
                if (pulse) start = 1;
            end
        end
        check("done_seen", seen, 1);
        check("latency", first_valid - s0, L + 2);
        check("all_pix", pix_exp.size(), 0);
        check("all_rd", rd_exp.size(), 0);
        pix_ready = 1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {busy, done, mem_rd_en, mem_addr, pix_valid, pix_last, pix_x, pix_y, pix_data}, 0);
        @(posedge clk);
        #1;
        reset = 0;
        repeat (5) begin
            @(negedge clk);
            check("idle", {busy, done, mem_rd_en, pix_valid}, 0);
        end
        mon_en = 1;
        run_frame(3, 1, 0, 0, 0);
        run_frame(3, 1, 1, 0, 0);
        run_frame(0, 0, 0, 0, 0);
        run_frame(2, 1, 2, 1, 0);
        run_frame(1, 1, 0, 0, 0);
        run_frame(3, 1, 0, 0, 5);
        run_frame(3, 1, 0, 0, 0);
        repeat (10) run_frame($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 2), 0, 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
